// File: rtl/uart_sample_arbiter_if.sv
// Handshake bundle between the sample sources, the arbiter and the UART TX core.
// The bench drives the master side; the arbiter sits on the slave side.
interface uart_sample_arbiter_if #(
    parameter int NUM_CH = 4
);
    logic                   in_en;
    logic [NUM_CH-1:0]      in_valid;
    logic [16*NUM_CH-1:0]   in_samples;
    logic [NUM_CH-1:0]      out_ready;
    logic                   tx_busy;
    logic                   out_tx_start;
    logic [7:0]             out_tx_data;
    logic                   out_busy;
    logic [15:0]            out_pkt_count;

    modport master (
        output in_en,
        output in_valid,
        output in_samples,
        output tx_busy,
        input  out_ready,
        input  out_tx_start,
        input  out_tx_data,
        input  out_busy,
        input  out_pkt_count
    );

    modport slave (
        input  in_en,
        input  in_valid,
        input  in_samples,
        input  tx_busy,
        output out_ready,
        output out_tx_start,
        output out_tx_data,
        output out_busy,
        output out_pkt_count
    );
endinterface

// File: rtl/uart_sample_arbiter.sv
// Round-robin arbiter packing one 16-bit sample per packet onto a shared byte UART.
// Packet: [HEADER][id][sample lo][sample hi]; header optional.
module uart_sample_arbiter #(
    parameter int          NUM_CH    = 4,
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter bit          HEADER_EN = 1'b1
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    uart_sample_arbiter_if.slave  bus
);
    localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   w_win;
    logic              w_found;
    logic              w_grant;
    logic              w_last;
    logic              w_advance;
    logic [1:0]        r_idx;
    logic [15:0]       r_sample;
    logic [NUM_CH-1:0] r_ready;
    logic [7:0]        r_tx_data;
    logic [7:0]        w_byte;
    logic [15:0]       r_pkt_count;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        int k;
        k       = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = (int'(r_rr_ptr) + i) % NUM_CH;
            if (!w_found && bus.in_valid[k]) begin
                w_found = 1'b1;
                w_win   = ID_W'(k);
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_grant   = 1'b0;
        w_last    = 1'b0;
        w_advance = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_en && !bus.tx_busy && w_found) begin
                    w_grant   = 1'b1;
                    w_state_n = S_SEND;
                end
            end
            S_SEND: w_state_n = S_HOLD;
            S_HOLD: w_state_n = S_WAIT;
            S_WAIT: begin
                if (!bus.tx_busy) begin
                    if (r_idx == 2'd3) begin
                        w_last    = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_advance = 1'b1;
                        w_state_n = S_SEND;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte = HEADER;
        unique case (r_idx)
            2'd0: w_byte = HEADER;
            2'd1: w_byte = 8'(r_id);
            2'd2: w_byte = r_sample[7:0];
            2'd3: w_byte = r_sample[15:8];
            default: w_byte = HEADER;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_idx       <= 2'd0;
            r_sample    <= '0;
            r_ready     <= '0;
            r_tx_data   <= '0;
            r_pkt_count <= '0;
        end else begin
            r_ready <= '0;
            if (w_grant) begin
                r_sample <= bus.in_samples[16*w_win +: 16];
                r_id     <= w_win;
                r_ready  <= NUM_CH'(1) << w_win;
                r_rr_ptr <= ID_W'((int'(w_win) + 1) % NUM_CH);
                r_idx    <= HEADER_EN ? 2'd0 : 2'd1;
            end
            if (r_state == S_SEND) begin
                r_tx_data <= w_byte;
            end
            if (w_advance) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_last) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    // Byte is presented combinationally while sending, then held.
    assign bus.out_ready     = r_ready;
    assign bus.out_tx_start  = (r_state == S_SEND);
    assign bus.out_tx_data   = (r_state == S_SEND) ? w_byte : r_tx_data;
    assign bus.out_busy      = (r_state != S_IDLE);
    assign bus.out_pkt_count = r_pkt_count;
endmodule

// File: tb/tb_uart_sample_arbiter.sv
// Directed bench for uart_sample_arbiter: two instances (header on/off)
// each driving a simple UART model that stays busy 10 cycles per byte.
module tb_uart_sample_arbiter;
    logic clk;
    logic rst;
    int   c1;
    int   c2;
    int   n_tests;
    int   n_fail;
    int   overlap;
    bit   sel;
    logic [7:0] q_bytes[$];
    logic [3:0] q_ready[$];

    uart_sample_arbiter_if #(.NUM_CH(4)) b1 ();
    uart_sample_arbiter_if #(.NUM_CH(4)) b2 ();

    uart_sample_arbiter #(
        .NUM_CH(4), .HEADER(8'hA5), .HEADER_EN(1'b1)
    ) dut1 (
        .in_clk(clk), .in_rst(rst), .bus(b1.slave)
    );

    uart_sample_arbiter #(
        .NUM_CH(4), .HEADER(8'hA5), .HEADER_EN(1'b0)
    ) dut2 (
        .in_clk(clk), .in_rst(rst), .bus(b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: not reset, so it finishes its byte on its own.
    always @(posedge clk) begin
        if (b1.out_tx_start) c1 <= 10;
        else if (c1 != 0) c1 <= c1 - 1;
        if (b2.out_tx_start) c2 <= 10;
        else if (c2 != 0) c2 <= c2 - 1;
    end
    assign b1.tx_busy = (c1 != 0);
    assign b2.tx_busy = (c2 != 0);

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n_pkts, input bit clr, input int en_drop,
                       input int stop_bytes, input int limit);
        logic [15:0] tgt;
        logic [15:0] cnt;
        logic        st;
        logic        bz;
        logic [7:0]  dt;
        logic [3:0]  rd;
        int          cyc;
        q_bytes.delete();
        q_ready.delete();
        cnt = sel ? b2.out_pkt_count : b1.out_pkt_count;
        tgt = cnt + 16'(n_pkts);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            st  = sel ? b2.out_tx_start : b1.out_tx_start;
            bz  = sel ? b2.tx_busy : b1.tx_busy;
            dt  = sel ? b2.out_tx_data : b1.out_tx_data;
            rd  = sel ? b2.out_ready : b1.out_ready;
            cnt = sel ? b2.out_pkt_count : b1.out_pkt_count;
            if (st) begin
                q_bytes.push_back(dt);
                if (bz) overlap++;
                if (q_bytes.size() == en_drop) begin
                    if (sel) b2.in_en = 1'b0;
                    else b1.in_en = 1'b0;
                end
            end
            if (rd != 4'b0) begin
                q_ready.push_back(rd);
                if (clr) begin
                    if (sel) b2.in_valid = b2.in_valid & ~rd;
                    else b1.in_valid = b1.in_valid & ~rd;
                end
            end
            if (stop_bytes > 0 && q_bytes.size() == stop_bytes) break;
            if (stop_bytes == 0 && cnt == tgt) break;
            if (cyc >= limit) begin
                n_tests++;
                n_fail++;
                $display("FAIL run_timeout: got %0d bytes, count %h, wanted count %h",
                         q_bytes.size(), cnt, tgt);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests += 5;
        if (b1.out_ready !== 4'b0) begin
            n_fail++; $display("FAIL rst_ready: got %b want 0000", b1.out_ready);
        end
        if (b1.out_tx_start !== 1'b0) begin
            n_fail++; $display("FAIL rst_start: got %b want 0", b1.out_tx_start);
        end
        if (b1.out_tx_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_data: got %h want 00", b1.out_tx_data);
        end
        if (b1.out_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy: got %b want 0", b1.out_busy);
        end
        if (b1.out_pkt_count !== 16'h0) begin
            n_fail++; $display("FAIL rst_count: got %h want 0000", b1.out_pkt_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h00, 8'h34, 8'h12};
        b1.in_samples[15:0] = 16'h1234;
        b1.in_en    = 1'b1;
        b1.in_valid = 4'b0001;
        run(1, 1'b1, -1, 0, 200);
        n_tests++;
        if (q_bytes.size() != 4) begin
            n_fail++; $display("FAIL single_nbytes: got %0d want 4", q_bytes.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (q_bytes[i] !== exp[i]) begin
                n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, q_bytes[i], exp[i]);
            end
        end
        n_tests += 4;
        if (q_ready.size() != 1 || q_ready[0] !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %0d pulses first %b want 1 x 0001",
                               q_ready.size(), q_ready[0]);
        end
        if (b1.out_pkt_count !== 16'd1) begin
            n_fail++; $display("FAIL single_count: got %h want 0001", b1.out_pkt_count);
        end
        if (b1.out_busy !== 1'b0) begin
            n_fail++; $display("FAIL single_busy: got %b want 0", b1.out_busy);
        end
        if (b1.in_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_served: valid %b want 0000", b1.in_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        overlap = 0;
        b1.in_samples = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        b1.in_valid   = 4'b1111;
        run(8, 1'b0, -1, 0, 1000);
        b1.in_valid = 4'b0000;
        n_tests++;
        if (q_bytes.size() != 32) begin
            n_fail++; $display("FAIL rr_nbytes: got %0d want 32", q_bytes.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_tests += 2;
            if (q_bytes[4*i+1] !== 8'(i % 4)) begin
                n_fail++; $display("FAIL rr_id%0d: got %h want %h", i, q_bytes[4*i+1], 8'(i % 4));
            end
            if (q_ready[i] !== (4'b0001 << (i % 4))) begin
                n_fail++; $display("FAIL rr_ready%0d: got %b want %b", i, q_ready[i],
                                   4'b0001 << (i % 4));
            end
        end
        n_tests++;
        if (overlap != 0) begin
            n_fail++; $display("FAIL rr_overlap: got %0d starts while busy want 0", overlap);
        end
    endtask

    task automatic test_rr_pointer();
        do_reset();
        b1.in_valid = 4'b0010;
        run(1, 1'b1, -1, 0, 200);
        b1.in_valid = 4'b1001;
        run(2, 1'b1, -1, 0, 400);
        n_tests += 3;
        if (q_ready.size() != 2) begin
            n_fail++; $display("FAIL ptr_npulses: got %0d want 2", q_ready.size());
        end
        if (q_ready[0] !== 4'b1000) begin
            n_fail++; $display("FAIL ptr_first: got %b want 1000", q_ready[0]);
        end
        if (q_ready[1] !== 4'b0001) begin
            n_fail++; $display("FAIL ptr_second: got %b want 0001", q_ready[1]);
        end
    endtask

    task automatic test_enable();
        bit bad;
        do_reset();
        b1.in_samples[15:0] = 16'h5678;
        b1.in_valid = 4'b0011;
        run(1, 1'b1, 3, 0, 200);
        n_tests += 3;
        if (q_bytes.size() != 4) begin
            n_fail++; $display("FAIL en_nbytes: got %0d want 4", q_bytes.size());
        end
        if (q_bytes[3] !== 8'h56) begin
            n_fail++; $display("FAIL en_lastbyte: got %h want 56", q_bytes[3]);
        end
        if (b1.in_en !== 1'b0) begin
            n_fail++; $display("FAIL en_dropped: in_en %b want 0", b1.in_en);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b1.out_ready !== 4'b0 || b1.out_busy !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL en_hold: got activity while in_en=0 want none");
        end
        b1.in_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (b1.out_ready !== 4'b0010) begin
            n_fail++; $display("FAIL en_resume: got %b want 0010", b1.out_ready);
        end
        b1.in_valid = 4'b0000;
        run(1, 1'b1, -1, 0, 200);
        n_tests++;
        if (b1.out_pkt_count !== 16'd2) begin
            n_fail++; $display("FAIL en_count: got %h want 0002", b1.out_pkt_count);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h02, 8'hFE, 8'hCA};
        b1.in_samples[47:32] = 16'hCAFE;
        b1.in_valid = 4'b0100;
        run(1, 1'b1, -1, 2, 200);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (b1.out_busy !== 1'b1) begin
            n_fail++; $display("FAIL mrst_inwait: busy %b want 1", b1.out_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests += 4;
        if (b1.out_busy !== 1'b0 || b1.out_tx_start !== 1'b0) begin
            n_fail++; $display("FAIL mrst_state: busy %b start %b want 0 0",
                               b1.out_busy, b1.out_tx_start);
        end
        if (b1.out_tx_data !== 8'h00) begin
            n_fail++; $display("FAIL mrst_data: got %h want 00", b1.out_tx_data);
        end
        if (b1.out_ready !== 4'b0) begin
            n_fail++; $display("FAIL mrst_ready: got %b want 0000", b1.out_ready);
        end
        if (b1.out_pkt_count !== 16'h0) begin
            n_fail++; $display("FAIL mrst_count: got %h want 0000", b1.out_pkt_count);
        end
        rst = 1'b0;
        b1.in_valid = 4'b0100;
        run(1, 1'b1, -1, 0, 300);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (q_bytes[i] !== exp[i]) begin
                n_fail++; $display("FAIL mrst_byte%0d: got %h want %h", i, q_bytes[i], exp[i]);
            end
        end
        n_tests++;
        if (b1.out_pkt_count !== 16'd1) begin
            n_fail++; $display("FAIL mrst_count2: got %h want 0001", b1.out_pkt_count);
        end
    endtask

    task automatic test_no_header();
        logic [7:0] exp [3];
        exp = '{8'h02, 8'hEF, 8'hBE};
        sel = 1'b1;
        b2.in_samples[47:32] = 16'hBEEF;
        b2.in_en    = 1'b1;
        b2.in_valid = 4'b0100;
        run(1, 1'b1, -1, 0, 200);
        n_tests++;
        if (q_bytes.size() != 3) begin
            n_fail++; $display("FAIL nohdr_nbytes: got %0d want 3", q_bytes.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (q_bytes[i] !== exp[i]) begin
                n_fail++; $display("FAIL nohdr_byte%0d: got %h want %h", i, q_bytes[i], exp[i]);
            end
        end
        n_tests++;
        if (b2.out_pkt_count !== 16'd1) begin
            n_fail++; $display("FAIL nohdr_count: got %h want 0001", b2.out_pkt_count);
        end
        @(negedge clk);
        force dut2.r_pkt_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut2.r_pkt_count;
        @(negedge clk);
        n_tests++;
        if (b2.out_pkt_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_preload: got %h want FFFF", b2.out_pkt_count);
        end
        b2.in_valid = 4'b0100;
        run(1, 1'b1, -1, 0, 200);
        n_tests++;
        if (b2.out_pkt_count !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_count: got %h want 0000", b2.out_pkt_count);
        end
        sel = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        overlap = 0;
        sel     = 1'b0;
        rst     = 1'b1;
        b1.in_en      = 1'b0;
        b1.in_valid   = '0;
        b1.in_samples = '0;
        b2.in_en      = 1'b0;
        b2.in_valid   = '0;
        b2.in_samples = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_rr_pointer();
        test_enable();
        test_mid_reset();
        test_no_header();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
